vertex_rasterize_pipe: RTL and testbench

//  Parametrised, handshaked successor of the single-vertex rasterizer.

---
 rtl/vertex_rasterize_pipe_pkg.sv | 15 +
 rtl/vertex_rasterize_pipe_f16.sv | 25 ++
 rtl/vertex_rasterize_pipe.sv | 133 +++++++++++++
 tb/tb_vertex_rasterize_pipe.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/vertex_rasterize_pipe_pkg.sv
// vertex_rasterize_pipe_pkg: shared constants, lane type and f16 classification for the rasterizer pipe
package vertex_rasterize_pipe_pkg;
   localparam int RAST_COORD_W = 13;
   localparam logic [15:0] F16_ONE = 16'h3C00;
   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} f16_class_e;
   typedef struct packed {
      logic signed [RAST_COORD_W-1:0] z;
      logic signed [RAST_COORD_W-1:0] y;
      logic signed [RAST_COORD_W-1:0] x;
   } rast_lane_t;
   // Denormals are folded into ZERO: they are far below one fixed-point LSB
   function automatic f16_class_e f16_class(input logic [15:0] f);
      return (f[14:10] == 5'd0) ? ZERO : (f[14:10] != 5'h1F) ? NORM : (f[9:0] == 10'd0) ? INF : NAN;
   endfunction
endpackage

// File: rtl/vertex_rasterize_pipe_f16.sv
// f16_to_fixed: combinational f16 -> signed fixed point (FRAC_W fractional bits, FX_W total)
//   f_i  : half-precision input
//   fx_o : signed fixed-point result; zero/denormal/NaN -> 0, inf/overflow -> +/- full scale
module f16_to_fixed
   import vertex_rasterize_pipe_pkg::*;
#(
   parameter int FX_W   = 24,
   parameter int FRAC_W = 10
) (
   input  logic [15:0]            f_i,
   output logic signed [FX_W-1:0] fx_o
);
   localparam int WIDE_W = 42;
   localparam logic [WIDE_W-1:0] MAX_MAG = (WIDE_W'(1) << (FX_W - 1)) - 1;
   f16_class_e cls;
   logic [WIDE_W-1:0] mag;
   logic [FX_W-1:0] lim;
   always_comb begin
      cls = f16_class(f_i);
      // value = sig * 2^(e-25); in FRAC_W fixed point that is sig << e >> (25-FRAC_W)
      mag = (WIDE_W'({1'b1, f_i[9:0]}) << f_i[14:10]) >> (25 - FRAC_W);
      lim = (cls == INF || mag > MAX_MAG) ? MAX_MAG[FX_W-1:0] : mag[FX_W-1:0];
      fx_o = (cls == ZERO || cls == NAN) ? '0 : f_i[15] ? -$signed(lim) : $signed(lim);
   end
endmodule

// File: rtl/vertex_rasterize_pipe.sv
// vertex_rasterize_pipe: 4-stage stallable f16 NDC/view-z to signed raster coordinate mapper
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input beat handshake (ndc_pt {y,x} f16 per lane, vertex_z f16 per lane, img_w/img_h)
//   out_valid/out_ready : output handshake (rast_pt {z,y,x} signed per lane, oob per lane)
//   Optional macro RAST_CLIP_FLAG_EN enables the per-lane out-of-bounds flag; otherwise oob is 0.
module vertex_rasterize_pipe
   import vertex_rasterize_pipe_pkg::*;
#(
   parameter int LANES   = 1,
   parameter int COORD_W = RAST_COORD_W,
   parameter int DIM_W   = 12,
   parameter int FRAC_W  = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*32-1:0]        ndc_pt,
   input  logic [LANES*16-1:0]        vertex_z,
   input  logic [DIM_W-1:0]           img_w,
   input  logic [DIM_W-1:0]           img_h,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*3*COORD_W-1:0] rast_pt,
   output logic [LANES-1:0]           oob
);
   localparam int FX_W = COORD_W + 1 + FRAC_W;
   localparam int YF_W = FX_W + 1;
   localparam int P_W  = YF_W + DIM_W + 1;
   localparam logic signed [YF_W-1:0] ONE_FX  = YF_W'(1) << FRAC_W;
   localparam logic signed [P_W-1:0]  HALF    = P_W'(1) << (FRAC_W - 1);
   localparam logic signed [P_W-1:0]  HALF_M1 = HALF - 1;
   localparam logic signed [P_W-1:0]  C_MAX   = (P_W'(1) << (COORD_W - 1)) - 1;
   localparam logic signed [P_W-1:0]  C_MIN   = ~C_MAX;
   // Returns {saturated, value}; negative inputs add half-1 so ties round away from zero
   function automatic logic [COORD_W:0] rnd_sat(input logic signed [P_W-1:0] v);
      logic signed [P_W-1:0] q;
      q = (v + (v[P_W-1] ? HALF_M1 : HALF)) >>> FRAC_W;
      return (q > C_MAX) ? {1'b1, C_MAX[COORD_W-1:0]} : (q < C_MIN) ? {1'b1, C_MIN[COORD_W-1:0]} : {1'b0, q[COORD_W-1:0]};
   endfunction
   logic rdy_q;
   logic [3:0] v_q;
   logic [DIM_W-1:0] w1_q, h1_q, w2_q, h2_q;
   logic en;
   assign en        = !v_q[3] || out_ready;
   assign in_ready  = en && rdy_q;
   assign out_valid = v_q[3];
   // rdy_q keeps in_ready low for the first cycle after reset release
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rdy_q <= 1'b0;
         v_q   <= '0;
         w1_q  <= '0;
         h1_q  <= '0;
         w2_q  <= '0;
         h2_q  <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (en) begin
            v_q  <= {v_q[2:0], in_valid && rdy_q};
            w1_q <= img_w;
            h1_q <= img_h;
            w2_q <= w1_q;
            h2_q <= h1_q;
         end
      end
`ifdef RAST_CLIP_FLAG_EN
   logic [DIM_W-1:0] w3_q, h3_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         w3_q <= '0;
         h3_q <= '0;
      end else if (en) begin
         w3_q <= w2_q;
         h3_q <= h2_q;
      end
`endif
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [FX_W-1:0] xc, yc, zc, x1_q, y1_q, z1_q, x2_q, z2_q, z3_q;
      logic signed [YF_W-1:0] y2_q;
      logic signed [P_W-1:0] x3_q, y3_q;
      logic [COORD_W:0] xs, ys, zs;
      logic [3*COORD_W-1:0] r_d, r_q;
      f16_to_fixed #(.FX_W(FX_W), .FRAC_W(FRAC_W)) u_x (.f_i(ndc_pt[32*l +: 16]), .fx_o(xc));
      f16_to_fixed #(.FX_W(FX_W), .FRAC_W(FRAC_W)) u_y (.f_i(ndc_pt[32*l+16 +: 16]), .fx_o(yc));
      // Depth is distance in front of the camera, so the sign of z_view is flipped before conversion
      f16_to_fixed #(.FX_W(FX_W), .FRAC_W(FRAC_W)) u_z (.f_i({~vertex_z[16*l+15], vertex_z[16*l +: 15]}), .fx_o(zc));
      assign xs  = rnd_sat(x3_q);
      assign ys  = rnd_sat(y3_q);
      assign zs  = rnd_sat(P_W'(z3_q));
      assign r_d = {zs[COORD_W-1:0], ys[COORD_W-1:0], xs[COORD_W-1:0]};
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            x1_q <= '0;
            y1_q <= '0;
            z1_q <= '0;
            x2_q <= '0;
            y2_q <= '0;
            z2_q <= '0;
            x3_q <= '0;
            y3_q <= '0;
            z3_q <= '0;
            r_q  <= '0;
         end else if (en) begin
            x1_q <= xc;
            y1_q <= yc;
            z1_q <= zc;
            x2_q <= x1_q;
            y2_q <= ONE_FX - YF_W'(y1_q);
            z2_q <= z1_q;
            x3_q <= P_W'(x2_q) * P_W'($signed({1'b0, w2_q}));
            y3_q <= P_W'(y2_q) * P_W'($signed({1'b0, h2_q}));
            z3_q <= z2_q;
            r_q  <= r_d;
         end
      assign rast_pt[3*COORD_W*l +: 3*COORD_W] = r_q;
`ifdef RAST_CLIP_FLAG_EN
      logic oob_d, oob_q;
      assign oob_d = xs[COORD_W] || ys[COORD_W] || zs[COORD_W] || xs[COORD_W-1] || ys[COORD_W-1]
                  || int'($signed(xs[COORD_W-1:0])) >= int'(w3_q)
                  || int'($signed(ys[COORD_W-1:0])) >= int'(h3_q)
                  || int'($signed(zs[COORD_W-1:0])) <= 0;
      always_ff @(posedge clk or posedge rst)
         if (rst) oob_q <= 1'b0;
         else if (en) oob_q <= oob_d;
      assign oob[l] = oob_q;
`else
      logic unused_sat;
      assign unused_sat = ^{xs[COORD_W], ys[COORD_W], zs[COORD_W]};
      assign oob[l] = 1'b0;
`endif
   end
endmodule

// File: tb/tb_vertex_rasterize_pipe.sv
// tb_vertex_rasterize_pipe: directed self-checking bench for vertex_rasterize_pipe (LANES=1 and LANES=4)
module tb_vertex_rasterize_pipe;
   import vertex_rasterize_pipe_pkg::*;
   typedef struct {logic [15:0] x, y, z; int w, h, ex, ey, ez; bit eo;} vec_t;
   localparam int N = 9;
   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, out_valid, out_ready;
   logic [31:0] ndc_pt;
   logic [15:0] vertex_z;
   logic [11:0] img_w, img_h;
   logic [38:0] rast_pt, prev_pt;
   logic [0:0] oob;
   logic in_valid4, in_ready4, out_valid4, out_ready4;
   logic [127:0] ndc_pt4;
   logic [63:0] vertex_z4;
   logic [155:0] rast_pt4;
   logic [3:0] oob4;
   int total = 0, bad = 0, ki, ko;
   bit prev_stall;
   vec_t tv [N];
   vertex_rasterize_pipe u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ndc_pt(ndc_pt), .vertex_z(vertex_z),
      .img_w(img_w), .img_h(img_h), .out_valid(out_valid), .out_ready(out_ready), .rast_pt(rast_pt), .oob(oob));
   vertex_rasterize_pipe #(.LANES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .ndc_pt(ndc_pt4), .vertex_z(vertex_z4),
      .img_w(img_w), .img_h(img_h), .out_valid(out_valid4), .out_ready(out_ready4), .rast_pt(rast_pt4), .oob(oob4));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic vec_t mk(logic [15:0] x, y, z, int w, h, ex, ey, ez, bit eo);
      vec_t v;
      v.x = x; v.y = y; v.z = z; v.w = w; v.h = h; v.ex = ex; v.ey = ey; v.ez = ez; v.eo = eo;
      return v;
   endfunction
   function automatic logic [38:0] exp_rast(vec_t v);
      rast_lane_t r;
      r.z = 13'(v.ez); r.y = 13'(v.ey); r.x = 13'(v.ex);
      return r;
   endfunction
   function automatic logic exp_oob(vec_t v);
`ifdef RAST_CLIP_FLAG_EN
      return v.eo;
`else
      return 1'b0;
`endif
   endfunction
   task automatic drive(vec_t v);
      ndc_pt = {v.y, v.x}; vertex_z = v.z; img_w = 12'(v.w); img_h = 12'(v.h); in_valid = 1'b1;
   endtask
   initial begin
      tv[0] = mk(16'h3800, 16'h3400, 16'hC100, 320, 240, 160, 180, 3, 1'b0);
      tv[1] = mk(16'h0000, 16'h3C00, 16'hBC00, 320, 240, 0, 0, 1, 1'b0);
      tv[2] = mk(16'h3C00, 16'h3800, 16'hC100, 320, 240, 320, 120, 3, 1'b1);
      tv[3] = mk(16'h6800, 16'h7E00, 16'h7C00, 320, 240, 4095, 240, -4096, 1'b1);
      tv[4] = mk(16'hB800, 16'h0000, 16'h3C00, 320, 240, -160, 240, -1, 1'b1);
      tv[5] = mk(16'h3400, 16'h3000, 16'h3800, 2, 4, 1, 4, -1, 1'b1);
      tv[6] = mk(16'hB400, 16'h3A00, 16'hC500, 2, 4, -1, 1, 5, 1'b1);
      tv[7] = mk(16'h3A00, 16'h3800, 16'hBE00, 3, 3, 2, 2, 2, 1'b0);
      tv[8] = mk(16'h0001, 16'h8000, 16'hC100, 100, 50, 0, 50, 3, 1'b1);
      rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; out_ready4 = 1'b1;
      ndc_pt = '0; vertex_z = '0; ndc_pt4 = '0; vertex_z4 = '0; img_w = '0; img_h = '0;
      @(negedge clk);
      chk("reset_valid", out_valid, 0);
      chk("reset_pt", rast_pt, 0);
      chk("reset_oob", oob, 0);
      chk("reset_ready", in_ready, 0);
      chk("reset_valid4", out_valid4, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("ready_after_release", in_ready, 0);
      @(negedge clk);
      chk("ready_up", in_ready, 1);
      // single beat latency, both lane counts
      drive(tv[0]);
      in_valid4 = 1'b1;
      ndc_pt4 = {tv[4].y, tv[4].x, tv[2].y, tv[2].x, tv[1].y, tv[1].x, tv[0].y, tv[0].x};
      vertex_z4 = {tv[4].z, tv[2].z, tv[1].z, tv[0].z};
      @(negedge clk);
      in_valid = 1'b0; in_valid4 = 1'b0;
      chk("lat1", out_valid, 0);
      @(negedge clk);
      chk("lat2", out_valid, 0);
      @(negedge clk);
      chk("lat3", out_valid, 0);
      chk("lat3_4", out_valid4, 0);
      @(negedge clk);
      chk("lat4", out_valid, 1);
      chk("t1_pt", rast_pt, exp_rast(tv[0]));
      chk("t1_oob", oob, exp_oob(tv[0]));
      chk("l4_valid", out_valid4, 1);
      chk("l4_pt", rast_pt4, {exp_rast(tv[4]), exp_rast(tv[2]), exp_rast(tv[1]), exp_rast(tv[0])});
      chk("l4_oob", oob4, {exp_oob(tv[4]), exp_oob(tv[2]), exp_oob(tv[1]), exp_oob(tv[0])});
      @(negedge clk);
      // back-to-back stream, dims change per beat
      for (int i = 0; i < N + 5; i++) begin
         if (i >= 4 && i < N + 4) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_pt", rast_pt, exp_rast(tv[i-4]));
            chk("stream_oob", oob, exp_oob(tv[i-4]));
         end else chk("stream_idle", out_valid, 0);
         if (i < N) drive(tv[i]);
         else in_valid = 1'b0;
         @(negedge clk);
      end
      // backpressure: downstream ready one cycle in three
      ki = 0; ko = 0; prev_stall = 1'b0; prev_pt = '0;
      for (int c = 0; c < 150 && ko < N; c++) begin
         out_ready = (c % 3 == 0);
         if (ki < N) drive(tv[ki]);
         else in_valid = 1'b0;
         #1;
         chk("bp_ready", in_ready, !out_valid || out_ready);
         if (prev_stall) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_pt", rast_pt, prev_pt);
         end
         if (out_valid && out_ready) begin
            chk("bp_pt", rast_pt, exp_rast(tv[ko]));
            chk("bp_oob", oob, exp_oob(tv[ko]));
            ko++;
         end
         prev_stall = out_valid && !out_ready;
         prev_pt = rast_pt;
         if (in_valid && in_ready) ki++;
         @(negedge clk);
      end
      chk("bp_count", 160'(ko), 160'(N));
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_no_extra", out_valid, 0);
         @(negedge clk);
      end
      // reset with the pipe full
      for (int i = 0; i < 4; i++) begin
         drive(tv[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_pt", rast_pt, 0);
      chk("rst_oob", oob, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_ready_low", in_ready, 0);
      @(negedge clk);
      chk("rst_ready_high", in_ready, 1);
      for (int i = 0; i < 6; i++) begin
         chk("no_stale", out_valid, 0);
         @(negedge clk);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
